// File: rtl/sprite_linebuf_dual_if.sv
// Sprite line buffer bus: write-side sprite strobes, read-side display strobes,
// bank toggle and registered display outputs.
interface sprite_linebuf_dual_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 9
) ();
    logic          swap;
    logic          wr_cen;
    logic          wr_load;
    logic [AW-1:0] wr_start_x;
    logic [DW-1:0] wr_data;
    logic          rd_cen;
    logic          rd_load;
    logic [AW-1:0] rd_start_x;
    logic          rd_dir;
    logic [DW-1:0] rd_data;
    logic          rd_bank;

    modport master (
        output swap, wr_cen, wr_load, wr_start_x, wr_data,
        output rd_cen, rd_load, rd_start_x, rd_dir,
        input  rd_data, rd_bank
    );

    modport slave (
        input  swap, wr_cen, wr_load, wr_start_x, wr_data,
        input  rd_cen, rd_load, rd_start_x, rd_dir,
        output rd_data, rd_bank
    );
endinterface

// File: rtl/sprite_linebuf_dual.sv
// Ping-pong sprite line buffer: one bank is written by the sprite engine while the
// other is scanned out. Optional macro SPRITE_LINEBUF_CLEAR_ON_READ_EN blanks pixels as they are read.
module sprite_linebuf_dual #(
    parameter int unsigned   DW         = 8,
    parameter int unsigned   AW         = 9,
    parameter int unsigned   TRANS_BITS = 3,
    parameter logic [AW-1:0] RD_OFFSET  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    sprite_linebuf_dual_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [2][DEPTH];

    logic          rd_bank_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] rd_data_q;

    logic          pend_valid;
    logic          pend_bank;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;

    logic wr_step_c;
    logic rd_step_c;
    logic pend_trans_c;

    // A load on the same edge takes priority over the pixel strobe.
    assign wr_step_c    = bus.wr_cen && !bus.wr_load;
    assign rd_step_c    = bus.rd_cen && !bus.rd_load;
    assign pend_trans_c = &pend_data[TRANS_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_q  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_data_q  <= '1;
            pend_valid <= 1'b0;
            pend_bank  <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            if (bus.swap) begin
                rd_bank_q <= ~rd_bank_q;
            end

            if (bus.wr_load) begin
                wr_ptr <= bus.wr_start_x;
            end else if (bus.wr_cen) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            // The bank is latched with the pixel so a swap before commit cannot redirect it.
            pend_valid <= wr_step_c;
            if (wr_step_c) begin
                pend_bank <= ~rd_bank_q;
                pend_addr <= wr_ptr;
                pend_data <= bus.wr_data;
            end

            if (bus.rd_load) begin
                rd_ptr <= bus.rd_start_x - RD_OFFSET;
            end else if (bus.rd_cen) begin
                rd_ptr <= bus.rd_dir ? (rd_ptr + AW'(1)) : (rd_ptr - AW'(1));
            end

            if (rd_step_c) begin
                rd_data_q <= mem[rd_bank_q][rd_ptr];
            end
        end
    end

    // Pixel RAM: no reset; reads above see the pre-write contents of this edge.
    always_ff @(posedge clk) begin
        if (pend_valid && !pend_trans_c) begin
            mem[pend_bank][pend_addr] <= pend_data;
        end
`ifdef SPRITE_LINEBUF_CLEAR_ON_READ_EN
        if (rd_step_c) begin
            mem[rd_bank_q][rd_ptr] <= '1;
        end
`endif
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_bank = rd_bank_q;
endmodule

// File: tb/tb_sprite_linebuf_dual.sv
// Directed scoreboard bench for sprite_linebuf_dual (DW=8, AW=9, TRANS_BITS=3, RD_OFFSET=199).
module tb_sprite_linebuf_dual;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 9;
    localparam int          OFF = 199;
`ifdef SPRITE_LINEBUF_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [DW-1:0] exp_q [$];

    sprite_linebuf_dual_if #(.DW(DW), .AW(AW)) bus ();

    sprite_linebuf_dual #(
        .DW(DW), .AW(AW), .TRANS_BITS(3), .RD_OFFSET(9'd199)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        bus.swap    = 1'b0;
        bus.wr_cen  = 1'b0;
        bus.wr_load = 1'b0;
        bus.rd_cen  = 1'b0;
        bus.rd_load = 1'b0;
    endtask

    // One clock; a read strobed on this edge is scored right after it.
    task automatic tick(input string tag = "rd_data");
        logic          strobed;
        logic [DW-1:0] e;
        strobed = bus.rd_cen && !bus.rd_load;
        @(posedge clk);
        #1;
        if (strobed) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(tag, bus.rd_data, e);
            end
        end
        idle();
    endtask

    task automatic wr_at(input int x);
        bus.wr_load = 1'b1; bus.wr_start_x = AW'(x); tick();
    endtask

    task automatic wr_px(input logic [DW-1:0] d);
        bus.wr_cen = 1'b1; bus.wr_data = d; tick();
    endtask

    task automatic do_swap();
        bus.swap = 1'b1; tick();
    endtask

    task automatic rd_at(input int x);
        bus.rd_load = 1'b1; bus.rd_start_x = AW'(x + OFF); tick();
    endtask

    task automatic rd_px(input string tag, input logic dir, input logic [DW-1:0] e);
        bus.rd_cen = 1'b1; bus.rd_dir = dir; exp_q.push_back(e); tick(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        idle();
        bus.rd_dir = 1'b1;
        bus.wr_start_x = '0;
        bus.rd_start_x = '0;
        bus.wr_data = '0;
        tick(); tick();
        check("rst_rd_bank", 32'(bus.rd_bank), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'hFF);
        rst = 1'b0;
        tick();

        // basic write then read from the other bank
        wr_at(10); wr_px(8'h01); wr_px(8'h02); wr_px(8'h03); tick();
        do_swap();
        check("swap_bank", 32'(bus.rd_bank), 32'd1);
        rd_at(10);
        rd_px("basic_rd0", 1'b1, 8'h01);
        rd_px("basic_rd1", 1'b1, 8'h02);
        rd_px("basic_rd2", 1'b1, 8'h03);
        tick();
        check("rd_hold", 32'(bus.rd_data), 32'h03);

        // transparency over prior AA pixels
        wr_at(20); repeat (4) wr_px(8'hAA);
        wr_at(20); wr_px(8'h05); wr_px(8'h07); wr_px(8'h0F); wr_px(8'h06); tick();
        do_swap();
        check("swap_bank2", 32'(bus.rd_bank), 32'd0);
        rd_at(20);
        rd_px("trans0", 1'b1, 8'h05);
        rd_px("trans1", 1'b1, 8'hAA);
        rd_px("trans2", 1'b1, 8'hAA);
        rd_px("trans3", 1'b1, 8'h06);

        // flipped readout through the offset
        wr_at(300); wr_px(8'h11); wr_px(8'h22); wr_px(8'h33); tick();
        do_swap();
        bus.rd_load = 1'b1; bus.rd_start_x = 9'd501; tick();
        rd_px("flip0", 1'b0, 8'h33);
        rd_px("flip1", 1'b0, 8'h22);
        rd_px("flip2", 1'b0, 8'h11);

        // write wrap with swap on the second pixel edge
        wr_at(511); wr_px(8'h5A);
        bus.swap = 1'b1; wr_px(8'h6B);
        check("swap_bank3", 32'(bus.rd_bank), 32'd0);
        tick();
        rd_at(511);
        rd_px("wrap_up511", 1'b1, 8'h5A);
        rd_px("wrap_up0", 1'b0, 8'h6B);
        rd_px("wrap_dn511", 1'b0, CLR ? 8'hFF : 8'h5A);

        // load beats strobe
        bus.wr_cen = 1'b1; bus.wr_data = 8'h77; wr_at(40);
        wr_px(8'h44); tick();
        do_swap();
        rd_at(40);
        rd_px("load_wins", 1'b1, 8'h44);

        // reread after two swaps
        do_swap(); do_swap();
        rd_at(40);
        rd_px("reread40", 1'b1, CLR ? 8'hFF : 8'h44);
        rd_at(10);
        rd_px("reread10", 1'b1, CLR ? 8'hFF : 8'h01);
        rd_px("reread11", 1'b1, CLR ? 8'hFF : 8'h02);
        rd_px("reread12", 1'b1, CLR ? 8'hFF : 8'h03);

        // reset mid-line with a pending write into bank 0
        wr_at(100); wr_px(8'h12); tick();
        wr_at(100); wr_px(8'h99);
        rst = 1'b1;
        #1;
        check("midrst_bank", 32'(bus.rd_bank), 32'd0);
        check("midrst_data", 32'(bus.rd_data), 32'hFF);
        tick(); tick();
        rst = 1'b0;
        rd_px("rst_rd_ptr0", 1'b1, CLR ? 8'hFF : 8'h6B);
        rd_at(100);
        rd_px("pend_lost", 1'b1, 8'h12);
        wr_px(8'h3C); tick();
        do_swap();
        rd_at(0);
        rd_px("rst_wr_ptr0", 1'b1, 8'h3C);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
